// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, drives the I-cache request and tracks misses/redirects.
// Optional build macro IF_FETCH_PERF_CNT_EN adds saturating miss-cycle and redirect counters.
module if_fetch_unit #(
    parameter int              PC_W     = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall_i,
    input  logic            redirect_i,
    input  logic [PC_W-1:0] redirect_pc_i,
    output logic            icache_req_o,
    output logic [PC_W-1:0] icache_addr_o,
    input  logic            icache_stall_i,
    input  logic [31:0]     icache_rdata_i,
    output logic [31:0]     instruction_o,
    output logic [PC_W-1:0] incremented_PC_o,
    output logic            valid_o,
    output logic            fetch_stall_o,
`ifdef IF_FETCH_PERF_CNT_EN
    output logic [31:0]     perf_miss_cycles_o,
    output logic [31:0]     perf_redirects_o,
`endif
    output logic [1:0]      debug_state
);

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MISS    = 2'd1,
        DISCARD = 2'd2
    } state_t;

    state_t          state;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] pending_pc;
    logic [PC_W-1:0] pc_plus4;
    logic [PC_W-1:0] run_next_pc;
    logic            req_en;

    // I-cache handshake: a request is outstanding whenever icache_req_o=1; the word on
    // icache_rdata_i is accepted in exactly the req cycle where icache_stall_i=0, and
    // icache_addr_o is held constant for as long as icache_stall_i=1.
    assign pc_plus4         = pc + {{(PC_W-3){1'b0}}, 3'd4};
    assign icache_req_o     = req_en;
    assign icache_addr_o    = pc;
    assign incremented_PC_o = pc_plus4;
    assign fetch_stall_o    = req_en & icache_stall_i;
    assign valid_o          = req_en & ~icache_stall_i & ~redirect_i & (state != DISCARD);
    assign instruction_o    = valid_o ? icache_rdata_i : 32'd0;
    assign debug_state      = state;

    // Redirect outranks the load-use stall when a word is accepted.
    always_comb begin
        run_next_pc = pc_plus4;
        if (redirect_i)
            run_next_pc = redirect_pc_i;
        else if (stall_i)
            run_next_pc = pc;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc         <= RESET_PC;
            state      <= RUN;
            pending_pc <= '0;
            req_en     <= 1'b0;
        end else begin
            req_en <= 1'b1;
            if (req_en) begin
                case (state)
                    RUN, MISS: begin
                        if (icache_stall_i) begin
                            if (redirect_i) begin
                                pending_pc <= redirect_pc_i;
                                state      <= DISCARD;
                            end else begin
                                state <= MISS;
                            end
                        end else begin
                            pc    <= run_next_pc;
                            state <= RUN;
                        end
                    end
                    DISCARD: begin
                        // Last redirect wins; stall_i does not hold this load.
                        if (redirect_i)
                            pending_pc <= redirect_pc_i;
                        if (!icache_stall_i) begin
                            pc    <= redirect_i ? redirect_pc_i : pending_pc;
                            state <= RUN;
                        end
                    end
                    default: state <= RUN;
                endcase
            end
        end
    end

`ifdef IF_FETCH_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_miss_cycles_o <= 32'd0;
            perf_redirects_o   <= 32'd0;
        end else begin
            if (fetch_stall_o && (perf_miss_cycles_o != 32'hFFFF_FFFF))
                perf_miss_cycles_o <= perf_miss_cycles_o + 32'd1;
            if (redirect_i && (perf_redirects_o != 32'hFFFF_FFFF))
                perf_redirects_o <= perf_redirects_o + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Testbench for if_fetch_unit: directed plan scenarios plus random traffic against a
// transaction-level fetch model; a negedge monitor checks every cycle from a queue.
module tb_if_fetch_unit;

    logic        clk;
    logic        rst;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        icache_req;
    logic [31:0] icache_addr;
    logic        icache_stall;
    logic [31:0] icache_rdata;
    logic [31:0] instruction;
    logic [31:0] incremented_pc;
    logic        valid;
    logic        fetch_stall;
    logic [1:0]  debug_state;
`ifdef IF_FETCH_PERF_CNT_EN
    logic [31:0] perf_miss_cycles;
    logic [31:0] perf_redirects;
`endif

    if_fetch_unit #(.PC_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk              (clk),
        .rst              (rst),
        .stall_i          (stall),
        .redirect_i       (redirect),
        .redirect_pc_i    (redirect_pc),
        .icache_req_o     (icache_req),
        .icache_addr_o    (icache_addr),
        .icache_stall_i   (icache_stall),
        .icache_rdata_i   (icache_rdata),
        .instruction_o    (instruction),
        .incremented_PC_o (incremented_pc),
        .valid_o          (valid),
        .fetch_stall_o    (fetch_stall),
`ifdef IF_FETCH_PERF_CNT_EN
        .perf_miss_cycles_o (perf_miss_cycles),
        .perf_redirects_o   (perf_redirects),
`endif
        .debug_state      (debug_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    // ---------------- scoreboard ----------------
    // entry = {req, valid, fetch_stall, addr, pc+4, instruction}
    logic [98:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [98:0] e;
            e = exp_q.pop_front();
            check("req",         {31'd0, icache_req},  {31'd0, e[98]});
            check("valid",       {31'd0, valid},       {31'd0, e[97]});
            check("fetch_stall", {31'd0, fetch_stall}, {31'd0, e[96]});
            check("addr",        icache_addr,          e[95:64]);
            check("pc_plus4",    incremented_pc,       e[63:32]);
            check("instruction", instruction,          e[31:0]);
        end
    end

    // ---------------- reference model ----------------
    // A fetch either delivers (cache not stalling) or waits; a redirect seen while waiting
    // is remembered and replaces the PC once the wait ends, and the late word is thrown away.
    logic [31:0] m_pc;
    bit          m_started;
    bit          m_have_target;
    logic [31:0] m_target;
    int unsigned m_miss_cnt;
    int unsigned m_redir_cnt;

    task automatic model_reset();
        m_pc          = 32'h0000_0000;
        m_started     = 1'b0;
        m_have_target = 1'b0;
        m_target      = 32'd0;
        m_miss_cnt    = 0;
        m_redir_cnt   = 0;
    endtask

    // Called at posedge+1: drives one cycle, records its expected outputs, steps the model.
    task automatic drive_cycle(input logic st, input logic rd, input logic [31:0] rpc,
                               input logic ics);
        logic [31:0] rdata;
        logic        e_valid;
        logic        e_fstall;
        rdata        = $urandom();
        stall        = st;
        redirect     = rd;
        redirect_pc  = rpc;
        icache_stall = ics;
        icache_rdata = rdata;
        e_valid  = m_started && !ics && !rd && !m_have_target;
        e_fstall = m_started && ics;
        exp_q.push_back({m_started, e_valid, e_fstall, m_pc, m_pc + 32'd4,
                         e_valid ? rdata : 32'd0});
        if (rd) m_redir_cnt++;
        if (e_fstall) m_miss_cnt++;
        if (m_started) begin
            if (ics) begin
                if (rd) begin
                    m_have_target = 1'b1;
                    m_target      = rpc;
                end
            end else begin
                if (m_have_target) m_pc = rd ? rpc : m_target;
                else if (rd)       m_pc = rpc;
                else if (!st)      m_pc = m_pc + 32'd4;
                m_have_target = 1'b0;
            end
        end
        m_started = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 1'b0, 32'd0, 1'b0);
    endtask

    task automatic jump(input logic [31:0] target);
        drive_cycle(1'b0, 1'b1, target, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b1;
        stall        = 1'b0;
        redirect     = 1'b0;
        redirect_pc  = 32'd0;
        icache_stall = 1'b0;
        icache_rdata = 32'd0;
        model_reset();
        #1;
        check("rst_req",      {31'd0, icache_req},  32'd0);
        check("rst_valid",    {31'd0, valid},       32'd0);
        check("rst_instr",    instruction,          32'd0);
        check("rst_fstall",   {31'd0, fetch_stall}, 32'd0);
        check("rst_addr",     icache_addr,          32'h0000_0000);
        check("rst_pc_plus4", incremented_pc,       32'h0000_0004);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // bubble, then 0x0, 0x4, 0x8
        idle(4);
        // load-use stall for 2 cycles at 0x10
        jump(32'h10);
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        drive_cycle(1'b1, 1'b0, 32'd0, 1'b0);
        idle(2);
        // 4-cycle miss at 0x20
        jump(32'h20);
        for (int i = 0; i < 4; i++) drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        idle(2);
        // two redirects during a miss at 0x40: last one (0x200) wins
        jump(32'h40);
        drive_cycle(1'b0, 1'b0, 32'd0,   1'b1);
        drive_cycle(1'b0, 1'b1, 32'h100, 1'b1);
        drive_cycle(1'b0, 1'b1, 32'h200, 1'b1);
        drive_cycle(1'b0, 1'b0, 32'd0,   1'b1);
        drive_cycle(1'b0, 1'b0, 32'd0,   1'b0);
        idle(2);
        // redirect together with stall at 0x50
        jump(32'h50);
        drive_cycle(1'b1, 1'b1, 32'h80, 1'b0);
        idle(2);
        // stall_i ignored when a discarded miss ends
        jump(32'h60);
        drive_cycle(1'b0, 1'b1, 32'h300, 1'b1);
        drive_cycle(1'b1, 1'b0, 32'd0,   1'b0);
        idle(1);
        // PC wrap
        jump(32'hFFFF_FFF8);
        idle(3);

        // random traffic
        for (int i = 0; i < 400; i++) begin
            drive_cycle($urandom_range(3) == 0, $urandom_range(5) == 0,
                        $urandom() & 32'hFFFF_FFFC, $urandom_range(2) == 0);
        end

`ifdef IF_FETCH_PERF_CNT_EN
        check("perf_miss",  perf_miss_cycles, m_miss_cnt);
        check("perf_redir", perf_redirects,   m_redir_cnt);
`endif

        // reset asserted mid-miss, away from a clock edge
        jump(32'h700);
        drive_cycle(1'b0, 1'b0, 32'd0, 1'b1);
        stall        = 1'b0;
        redirect     = 1'b0;
        icache_stall = 1'b1;
        #1;
        check("pre_rst_fstall", {31'd0, fetch_stall}, 32'd1);
        rst = 1'b1;
        #1;
        check("async_rst_req",   {31'd0, icache_req}, 32'd0);
        check("async_rst_addr",  icache_addr,         32'h0000_0000);
        check("async_rst_valid", {31'd0, valid},      32'd0);
`ifdef IF_FETCH_PERF_CNT_EN
        check("async_rst_perf_miss",  perf_miss_cycles, 32'd0);
        check("async_rst_perf_redir", perf_redirects,   32'd0);
`endif
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(4);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
